otg_hpi_master: RTL and testbench
=================================

OTG_HPI_MASTER -- requirements
Module: otg_hpi_master

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, HPI data width; ADDR_W, default 2, HPI register-select width; MAX_BURST, default 8, maximum words per request; SETUP_CYC, default 2, cycles from chip-select to strobe (at least 1); STROBE_CYC, default 4, strobe width in cycles (at least 1); HOLD_CYC, default 1, cycles from strobe release to the next setup or to chip-select release (at least 1).
REQ-002 SHALL use LEN_W = clog2(MAX_BURST+1).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk_clk in 1, rising-edge clock; reset_reset in 1, async active-high reset.
REQ-004 SHALL have these request ports: req_valid in 1, request offered; req_ready out 1, request accepted this cycle; req_write in 1, 1 = write and 0 = read; req_addr in ADDR_W, HPI register select; req_len in LEN_W, word count.
REQ-005 SHALL have these write-data ports: wr_valid in 1, write word offered; wr_ready out 1, write word accepted; wr_data in DATA_W, write word.
REQ-006 SHALL have these read-data ports: rd_valid out 1, read word strobe, no backpressure; rd_data out DATA_W, read word; rd_last out 1, marks the final word of the request.
REQ-007 SHALL have these status ports: busy out 1, transaction in progress; done out 1, one-cycle completion pulse.
REQ-008 SHALL have these HPI ports: otg_hpi_address_export out ADDR_W, register select; otg_hpi_cs_export out 1, chip select, active-low; otg_hpi_r_export out 1, read strobe, active-low; otg_hpi_w_export out 1, write strobe, active-low; otg_hpi_data_out_port out DATA_W, write data; otg_hpi_data_in_port in DATA_W, read data.

Function
REQ-009 SHALL implement the states IDLE, WDATA, SETUP, STROBE, HOLD and FINISH, with one down-counter for phase timing and one word counter.
REQ-010 SHALL drive req_ready = 1 only in IDLE; a handshake is req_valid and req_ready both high at a rising edge.
REQ-011 SHALL, on a handshake, latch req_write and req_addr, and latch an effective length: req_len = 0 becomes 1, and req_len > MAX_BURST becomes MAX_BURST.
REQ-012 SHALL, after a handshake, go to WDATA for a write and to SETUP for a read.
REQ-013 SHALL drive wr_ready = 1 only in WDATA; on a wr handshake it captures wr_data into otg_hpi_data_out_port and moves to SETUP; otherwise it stays in WDATA indefinitely.
REQ-014 SHALL hold otg_hpi_cs_export low in WDATA, SETUP, STROBE and HOLD, and high in IDLE and FINISH.
REQ-015 SHALL, in SETUP, keep both strobes high and drive the latched address for SETUP_CYC cycles.
REQ-016 SHALL, in STROBE, hold r (read) or w (write) low for exactly STROBE_CYC cycles, and never assert both strobes at once.
REQ-017 SHALL, for reads, register otg_hpi_data_in_port on the final STROBE cycle, then pulse rd_valid for one cycle with rd_data on the following cycle; rd_last = 1 on the last word only.
REQ-018 SHALL, in HOLD, keep strobes high, address and data_out stable, and cs low for HOLD_CYC cycles.
REQ-019 SHALL, after HOLD, go to WDATA (write) or SETUP (read) if words remain, and otherwise go to FINISH.
REQ-020 SHALL keep the address constant for the whole burst, relying on the HPI data-port auto-increment.
REQ-021 SHALL spend exactly one cycle in FINISH, with done = 1, then return to IDLE.
REQ-022 SHALL drive busy = 1 in every state except IDLE.
REQ-023 SHALL ignore req_valid and keep req_ready = 0 while busy.
REQ-024 SHALL ignore wr_valid outside WDATA.
REQ-025 SHALL make the single-read latency from the handshake edge to rd_valid SETUP_CYC+STROBE_CYC cycles.
REQ-026 SHALL make a single read keep cs low for SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.

Reset
REQ-027 SHALL, while reset_reset = 1, asynchronously force the following: state IDLE; otg_hpi_cs_export, otg_hpi_r_export and otg_hpi_w_export all 1; otg_hpi_address_export and otg_hpi_data_out_port both 0; rd_data 0; rd_valid, rd_last, done, busy and wr_ready all 0; all counters 0.
REQ-028 SHALL make req_ready = 1 on the first cycle after reset is released.
REQ-029 SHALL, if reset is asserted mid-transaction, release all HPI strobes and cs immediately, drop the transaction, and produce no done or rd_valid pulse.

Verification
REQ-030 SHALL be covered by these directed scenarios (defaults: SETUP_CYC = 2, STROBE_CYC = 4, HOLD_CYC = 1):
- Reset pulse -> cs, r and w all 1; busy 0; req_ready 1 after release.
- Write, addr 2, len 1, wr_data 0x1234 offered with the request -> cs low for 1 WDATA cycle plus 7 cycles, w low for exactly 4 cycles, data_out 0x1234 stable throughout, r never low, a single done pulse.
- Read, addr 0, len 1, data_in 0xBEEF -> r low for 4 cycles, rd_valid exactly 1 cycle with rd_data 0xBEEF and rd_last 1, first rd_valid 6 cycles after the handshake.
- Write, len 3, wr_valid withheld 5 cycles before word 2 -> 3 w pulses, cs held low through the wait, address constant, done once.
- Read with len 0, then with len 15 -> 1 word and 8 words respectively; rd_last only on the final word; req_valid held during busy is not accepted.
- Reset asserted on the 2nd STROBE cycle of a read -> cs and r go high asynchronously, no rd_valid or done, and the next request completes normally.

Source files
------------

// File: rtl/otg_hpi_master.sv
// ============================================================================
// otg_hpi_master : burst read/write master for a host-port (HPI) interface
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module otg_hpi_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int MAX_BURST  = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,

  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,

  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,

  output logic              busy,
  output logic              done,

  output logic [ADDR_W-1:0] otg_hpi_address_export,
  output logic              otg_hpi_cs_export,
  output logic              otg_hpi_r_export,
  output logic              otg_hpi_w_export,
  output logic [DATA_W-1:0] otg_hpi_data_out_port,
  input  logic [DATA_W-1:0] otg_hpi_data_in_port
);

  localparam int C_MAXC_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int C_MAXC   = (C_MAXC_A > HOLD_CYC) ? C_MAXC_A : HOLD_CYC;
  localparam int CNT_W    = $clog2(C_MAXC + 1);

  localparam logic [CNT_W-1:0] C_SETUP_INIT  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_STROBE_INIT = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] C_HOLD_INIT   = CNT_W'(HOLD_CYC - 1);
  localparam logic [LEN_W-1:0] C_MAX_LEN     = LEN_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              cs_q, cs_d;
  logic              r_q, r_d;
  logic              w_q, w_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_ready_q, wr_ready_d;
  logic [LEN_W-1:0]  len_eff;

  always_comb begin
    if (req_len == '0)
      len_eff = LEN_W'(1);
    else if (req_len > C_MAX_LEN)
      len_eff = C_MAX_LEN;
    else
      len_eff = req_len;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    write_d    = write_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          words_d = len_eff;
          if (req_write) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_SETUP;
            cnt_d   = C_SETUP_INIT;
          end
        end
      end
      S_WDATA: begin
        if (wr_valid) begin
          dout_d  = wr_data;
          state_d = S_SETUP;
          cnt_d   = C_SETUP_INIT;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = C_STROBE_INIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = C_HOLD_INIT;
          words_d = words_q - 1'b1;
          // Read data is sampled on the last strobe cycle, presented one cycle later.
          if (!write_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = otg_hpi_data_in_port;
            rd_last_d  = (words_q == LEN_W'(1));
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (words_q != '0) begin
            state_d = write_q ? S_WDATA : S_SETUP;
            cnt_d   = write_q ? '0 : C_SETUP_INIT;
          end else begin
            state_d = S_FINISH;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin-level outputs are decoded from the next state so they register glitch-free.
    cs_d       = !(state_d inside {S_WDATA, S_SETUP, S_STROBE, S_HOLD});
    r_d        = !((state_d == S_STROBE) && !write_d);
    w_d        = !((state_d == S_STROBE) && write_d);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
    wr_ready_d = (state_d == S_WDATA);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      words_q    <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      cs_q       <= 1'b1;
      r_q        <= 1'b1;
      w_q        <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      cs_q       <= cs_d;
      r_q        <= r_d;
      w_q        <= w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign req_ready              = (state_q == S_IDLE);
  assign wr_ready               = wr_ready_q;
  assign rd_valid               = rd_valid_q;
  assign rd_data                = rd_data_q;
  assign rd_last                = rd_last_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign otg_hpi_address_export = addr_q;
  assign otg_hpi_cs_export      = cs_q;
  assign otg_hpi_r_export       = r_q;
  assign otg_hpi_w_export       = w_q;
  assign otg_hpi_data_out_port  = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_otg_hpi_master.sv
// ============================================================================
// tb_otg_hpi_master : scoreboard bench for otg_hpi_master
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_otg_hpi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic        done;
  logic [1:0]  hpi_addr;
  logic        hpi_cs, hpi_r, hpi_w;
  logic [15:0] hpi_dout;
  logic [15:0] hpi_din;

  otg_hpi_master dut (
    .clk_clk(clk), .reset_reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done),
    .otg_hpi_address_export(hpi_addr), .otg_hpi_cs_export(hpi_cs),
    .otg_hpi_r_export(hpi_r), .otg_hpi_w_export(hpi_w),
    .otg_hpi_data_out_port(hpi_dout), .otg_hpi_data_in_port(hpi_din)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t exp_rd[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Monitor-owned statistics; the stimulus only takes snapshots of them.
  int cs_lo = 0, r_lo = 0, w_lo = 0, w_fall = 0, both_lo = 0;
  int cs_hi_busy = 0, rr_busy = 0, addr_err = 0, dout_err = 0;
  int rv_cnt = 0, done_cnt = 0, last_rv_cyc = 0, pulse_cnt = 0;
  logic prev_r = 1'b1, prev_w = 1'b1;

  logic [1:0]  exp_addr = '0;
  logic [15:0] exp_dout = '0;
  logic [15:0] rd_base = '0;
  int          hs_cyc = 0;

  assign hpi_din = rd_base + 16'(pulse_cnt);

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_valid) begin
      rv_cnt++;
      last_rv_cyc = cyc;
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        e = exp_rd.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_last", 32'(rd_last), 32'(e.last));
      end
    end
    if (done) done_cnt++;
    if (!hpi_cs) cs_lo++;
    if (!hpi_r) r_lo++;
    if (!hpi_w) w_lo++;
    if (prev_w && !hpi_w) w_fall++;
    if (!prev_r && hpi_r) pulse_cnt++;
    if (!hpi_r && !hpi_w) both_lo++;
    if (busy && hpi_cs) cs_hi_busy++;
    if (busy && req_ready) rr_busy++;
    if (!hpi_cs && hpi_addr != exp_addr) addr_err++;
    if (!hpi_w && hpi_dout != exp_dout) dout_err++;
    prev_r = hpi_r;
    prev_w = hpi_w;
  end

  task automatic issue(input bit wr, input logic [1:0] addr, input logic [3:0] len, input bit hold);
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    exp_addr  = addr;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("req_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic write_words(input int n, input int gap_idx, input int gap, input logic [15:0] base);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == gap_idx) begin
        t = 0;
        while (!wr_ready && t < 100) begin
          @(negedge clk);
          t++;
        end
        repeat (gap) @(negedge clk);
      end
      wr_valid = 1'b1;
      wr_data  = base + 16'(i);
      t = 0;
      while (!wr_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("wr_timeout", 32'(wr_ready), 32'd1);
      @(posedge clk);
      #1;
      exp_dout = wr_data;
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int snap);
    int t;
    t = 0;
    while (done_cnt == snap && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("done_timeout", 32'(done_cnt - snap), 32'd1);
  endtask

  int s_cs, s_r, s_w, s_wf, s_both, s_chb, s_rrb, s_ae, s_de, s_rv, s_dn, s_pc;

  task automatic snap_all();
    s_cs = cs_lo; s_r = r_lo; s_w = w_lo; s_wf = w_fall; s_both = both_lo;
    s_chb = cs_hi_busy; s_rrb = rr_busy; s_ae = addr_err; s_de = dout_err;
    s_rv = rv_cnt; s_dn = done_cnt; s_pc = pulse_cnt;
  endtask

  task automatic push_reads(input int n, input logic [15:0] base);
    rd_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = base + 16'(i);
      e.last = (i == n - 1);
      exp_rd.push_back(e);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(hpi_cs), 32'd1);
    chk("rst_r", 32'(hpi_r), 32'd1);
    chk("rst_w", 32'(hpi_w), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {26'd0, wr_ready, rd_valid, done, rd_last, hpi_addr != 2'd0, hpi_dout != 16'd0}, 32'd0);
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Single write, addr 2
    snap_all();
    issue(1'b1, 2'd2, 4'd1, 1'b0);
    write_words(1, -1, 0, 16'h1234);
    wait_done(s_dn);
    repeat (2) @(negedge clk);
    chk("wr1_cs_low", 32'(cs_lo - s_cs), 32'd8);
    chk("wr1_w_low", 32'(w_lo - s_w), 32'd4);
    chk("wr1_r_low", 32'(r_lo - s_r), 32'd0);
    chk("wr1_w_pulses", 32'(w_fall - s_wf), 32'd1);
    chk("wr1_dout_err", 32'(dout_err - s_de), 32'd0);
    chk("wr1_dout", 32'(hpi_dout), 32'h1234);
    chk("wr1_done", 32'(done_cnt - s_dn), 32'd1);

    // Single read, addr 0, 0xBEEF
    snap_all();
    rd_base = 16'hBEEF - 16'(pulse_cnt);
    push_reads(1, 16'hBEEF);
    issue(1'b0, 2'd0, 4'd1, 1'b0);
    wait_done(s_dn);
    repeat (2) @(negedge clk);
    chk("rd1_r_low", 32'(r_lo - s_r), 32'd4);
    chk("rd1_cs_low", 32'(cs_lo - s_cs), 32'd7);
    chk("rd1_w_low", 32'(w_lo - s_w), 32'd0);
    chk("rd1_rv_count", 32'(rv_cnt - s_rv), 32'd1);
    chk("rd1_latency", 32'(last_rv_cyc - hs_cyc), 32'd6);
    chk("rd1_done", 32'(done_cnt - s_dn), 32'd1);

    // Three-word write with a stalled second word
    snap_all();
    issue(1'b1, 2'd3, 4'd3, 1'b0);
    write_words(3, 1, 5, 16'h5A00);
    wait_done(s_dn);
    repeat (2) @(negedge clk);
    chk("wr3_w_pulses", 32'(w_fall - s_wf), 32'd3);
    chk("wr3_w_low", 32'(w_lo - s_w), 32'd12);
    chk("wr3_cs_gap", 32'(cs_hi_busy - s_chb), 32'd1);
    chk("wr3_addr_err", 32'(addr_err - s_ae), 32'd0);
    chk("wr3_dout_err", 32'(dout_err - s_de), 32'd0);
    chk("wr3_done", 32'(done_cnt - s_dn), 32'd1);

    // Read len 0 -> one word, request held high while busy
    snap_all();
    rd_base = 16'hC000;
    push_reads(1, 16'hC000 + 16'(pulse_cnt));
    issue(1'b0, 2'd1, 4'd0, 1'b1);
    wait_done(s_dn);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("len0_rv_count", 32'(rv_cnt - s_rv), 32'd1);
    chk("len0_rr_busy", 32'(rr_busy - s_rrb), 32'd0);
    chk("len0_done", 32'(done_cnt - s_dn), 32'd1);

    // Read len 15 -> clamped to eight words
    snap_all();
    push_reads(8, 16'hC000 + 16'(pulse_cnt));
    issue(1'b0, 2'd1, 4'd15, 1'b1);
    wait_done(s_dn);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("len15_rv_count", 32'(rv_cnt - s_rv), 32'd8);
    chk("len15_r_low", 32'(r_lo - s_r), 32'd32);
    chk("len15_rr_busy", 32'(rr_busy - s_rrb), 32'd0);
    chk("len15_done", 32'(done_cnt - s_dn), 32'd1);
    chk("both_strobes_low", 32'(both_lo), 32'd0);

    // Reset on the second strobe cycle of a read
    snap_all();
    issue(1'b0, 2'd2, 4'd1, 1'b0);
    begin
      int t;
      t = 0;
      while (hpi_r && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("strobe_timeout", 32'(hpi_r), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cs", 32'(hpi_cs), 32'd1);
    chk("arst_r", 32'(hpi_r), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_no_rv", 32'(rv_cnt - s_rv), 32'd0);
    chk("arst_no_done", 32'(done_cnt - s_dn), 32'd0);

    // Normal two-word read after the aborted one
    snap_all();
    rd_base = 16'h7000;
    push_reads(2, 16'h7000 + 16'(pulse_cnt));
    issue(1'b0, 2'd0, 4'd2, 1'b0);
    wait_done(s_dn);
    repeat (3) @(negedge clk);
    chk("post_rv_count", 32'(rv_cnt - s_rv), 32'd2);
    chk("post_done", 32'(done_cnt - s_dn), 32'd1);
    chk("scoreboard_empty", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
